// File: rtl/prime_sieve_pkg.sv
// prime_sieve_pkg: shared FSM states, direction codes and start-value clamp for prime_sieve_stepper
package prime_sieve_pkg;
  typedef enum logic [2:0] {S_CLEAR, S_SCAN, S_MARK, S_COUNT, S_INIT, S_SEEK, S_READY} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic logic [31:0] clamp_start(input logic [31:0] v, input logic [31:0] max_n);
    return v < 32'd2 ? 32'd2 : (v > max_n ? max_n : v);
  endfunction
endpackage

// File: rtl/prime_sieve_stepper_bitmap.sv
// sieve_bitmap: 1-bit wide inferred RAM with one write port and one synchronous read port
module sieve_bitmap #(
  parameter int DEPTH = 1000000,
  parameter int BW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [BW-1:0] waddr,
  input  logic          wdata,
  input  logic [BW-1:0] raddr,
  output logic          rdata
);
  logic mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/prime_sieve_stepper.sv
// prime_sieve_stepper: sieves primes 0..MAX_N into a bitmap then steps through them on request (PRIME_COUNT_EN adds prime_total_o)
module prime_sieve_stepper
  import prime_sieve_pkg::*;
#(
  parameter int MAX_N = 999999,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dir_i,
  input  logic          step_i,
  input  logic          load_i,
  input  logic [AW-1:0] start_i,
  output logic [AW-1:0] prime_o,
  output logic          prime_valid_o,
  output logic          ready_o,
  output logic          step_done_o,
  output logic          wrap_o,
  output logic          sieve_done_o
`ifdef PRIME_COUNT_EN
  , output logic [AW-1:0] prime_total_o
`endif
);
  localparam int BW = $clog2(MAX_N + 1);
  localparam logic [AW-1:0] MAXA = AW'(MAX_N);
  localparam logic [AW:0] MAXW = (AW+1)'(MAX_N);
  localparam logic [2*AW-1:0] MAXS = (2*AW)'(MAX_N);
  localparam logic [AW-1:0] TWO = AW'(2);
  state_t state;
  logic [AW-1:0] i, cand, base, nxt;
  logic [AW:0] j, nj, inc;
  logic [2*AW-1:0] sq;
  logic ph, dir, wrapf, step_dir, nwrap, we, rdata;
  logic [BW-1:0] raddr;
`ifdef PRIME_COUNT_EN
  logic cv;
`endif
  always_comb begin
    we = state == S_CLEAR || state == S_MARK;
    raddr = state == S_SCAN ? BW'(i) : state == S_SEEK ? BW'(cand) : BW'(j);
    base = state == S_READY ? prime_o : cand;
    step_dir = state == S_READY ? dir_i : dir;
    inc = {1'b0, base} + (AW+1)'(1);
    nwrap = step_dir == DIR_DOWN ? base <= TWO : inc > MAXW;
    nxt = step_dir == DIR_DOWN ? (nwrap ? MAXA : base - AW'(1)) : (nwrap ? TWO : inc[AW-1:0]);
    nj = j + {1'b0, i};
    sq = {{AW{1'b0}}, i} * {{AW{1'b0}}, i};
  end
  sieve_bitmap #(.DEPTH(MAX_N + 1), .BW(BW)) u_bitmap (
    .clk,
    .we,
    .waddr(BW'(j)),
    .wdata(state == S_MARK),
    .raddr,
    .rdata
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      i <= TWO;
      j <= '0;
      cand <= '0;
      ph <= 1'b0;
      dir <= DIR_UP;
      wrapf <= 1'b0;
      prime_o <= '0;
      prime_valid_o <= 1'b0;
      ready_o <= 1'b0;
      step_done_o <= 1'b0;
      wrap_o <= 1'b0;
      sieve_done_o <= 1'b0;
`ifdef PRIME_COUNT_EN
      cv <= 1'b0;
      prime_total_o <= '0;
`endif
    end else begin
      step_done_o <= 1'b0;
      wrap_o <= 1'b0;
      case (state)
        S_CLEAR: begin
          j <= j + (AW+1)'(1);
          if (j == MAXW) begin
            state <= S_SCAN;
            i <= TWO;
            ph <= 1'b0;
          end
        end
        S_SCAN: begin
          ph <= ~ph;
          if (ph) begin
            if (sq > MAXS) begin
`ifdef PRIME_COUNT_EN
              state <= S_COUNT;
              j <= (AW+1)'(2);
              cv <= 1'b0;
`else
              state <= S_INIT;
`endif
            end else if (!rdata) begin
              state <= S_MARK;
              j <= sq[AW:0];
            end else i <= i + AW'(1);
          end
        end
        S_MARK: begin
          j <= nj;
          if (nj > MAXW) begin
            state <= S_SCAN;
            i <= i + AW'(1);
          end
        end
`ifdef PRIME_COUNT_EN
        S_COUNT: begin
          cv <= j <= MAXW;
          if (cv && !rdata) prime_total_o <= prime_total_o + AW'(1);
          if (j <= MAXW) j <= j + (AW+1)'(1);
          else state <= S_INIT;
        end
`endif
        S_INIT: begin
          sieve_done_o <= 1'b1;
          dir <= dir_i;
          cand <= dir_i == DIR_UP ? TWO : MAXA;
          wrapf <= 1'b0;
          ph <= 1'b0;
          state <= S_SEEK;
        end
        S_READY: begin
          if (load_i || step_i) begin
            ready_o <= 1'b0;
            dir <= dir_i;
            ph <= 1'b0;
            cand <= load_i ? AW'(clamp_start(32'(start_i), 32'(MAX_N))) : nxt;
            wrapf <= !load_i && nwrap;
            state <= S_SEEK;
          end
        end
        S_SEEK: begin
          ph <= ~ph;
          if (ph) begin
            if (!rdata) begin
              prime_o <= cand;
              prime_valid_o <= 1'b1;
              step_done_o <= 1'b1;
              wrap_o <= wrapf;
              ready_o <= 1'b1;
              state <= S_READY;
            end else begin
              cand <= nxt;
              wrapf <= wrapf | nwrap;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_prime_sieve_stepper.sv
// tb_prime_sieve_stepper: directed checks of sieve, stepping, loads, wrap, request dropping and reset
module tb_prime_sieve_stepper;
  localparam int MAX_N = 100;
  localparam int AW = 9;
  logic clk = 1'b0, rst = 1'b1, dir_i = 1'b1, step_i = 1'b0, load_i = 1'b0;
  logic [AW-1:0] start_i = '0;
  logic [AW-1:0] prime_o;
  logic prime_valid_o, ready_o, step_done_o, wrap_o, sieve_done_o;
`ifdef PRIME_COUNT_EN
  logic [AW-1:0] prime_total_o;
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  prime_sieve_stepper #(.MAX_N(MAX_N), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .dir_i(dir_i),
    .step_i(step_i),
    .load_i(load_i),
    .start_i(start_i),
    .prime_o(prime_o),
    .prime_valid_o(prime_valid_o),
    .ready_o(ready_o),
    .step_done_o(step_done_o),
    .wrap_o(wrap_o),
    .sieve_done_o(sieve_done_o)
`ifdef PRIME_COUNT_EN
    , .prime_total_o(prime_total_o)
`endif
  );
  task automatic request(input logic s, input logic l, input logic [AW-1:0] st, input logic d);
    @(negedge clk);
    step_i = s;
    load_i = l;
    start_i = st;
    dir_i = d;
    @(negedge clk);
    step_i = 1'b0;
    load_i = 1'b0;
  endtask
  task automatic wait_done(output bit ok, output int pulses, output bit wr);
    ok = 0;
    pulses = 0;
    wr = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (step_done_o) begin
        ok = 1;
        pulses++;
        wr = wrap_o;
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (step_done_o) pulses++;
    end
  endtask
  task automatic check_seek(input string name, input logic [AW-1:0] want, input bit want_wr);
    bit ok, wr;
    int p;
    wait_done(ok, p, wr);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s timeout got no step_done want step_done", name);
    end
    total++;
    if (prime_o !== want) begin
      bad++;
      $display("FAIL %s prime got %0d want %0d", name, prime_o, want);
    end
    total++;
    if (p != 1 || wr !== want_wr || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s handshake got pulses=%0d wrap=%0b ready=%0b want pulses=1 wrap=%0b ready=1", name, p, wr, ready_o, want_wr);
    end
  endtask
  task automatic check_zero(input string name);
    logic [AW+4:0] o;
    o = {prime_o, prime_valid_o, ready_o, step_done_o, wrap_o, sieve_done_o};
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL %s outputs got %h want 0", name, o);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    dir_i = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b0;
    repeat (50) @(negedge clk);
    total++;
    if (sieve_done_o !== 1'b0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL early_done got sieve_done=%0b ready=%0b want 0 0", sieve_done_o, ready_o);
    end
    check_seek("init_up", AW'(2), 1'b0);
    total++;
    if (sieve_done_o !== 1'b1 || prime_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL sieve_done got sieve_done=%0b valid=%0b want 1 1", sieve_done_o, prime_valid_o);
    end
`ifdef PRIME_COUNT_EN
    total++;
    if (prime_total_o !== AW'(25)) begin
      bad++;
      $display("FAIL prime_total got %0d want 25", prime_total_o);
    end
`endif
  endtask
  task automatic test_step_up();
    logic [AW-1:0] exp [3] = '{AW'(3), AW'(5), AW'(7)};
    for (int k = 0; k < 3; k++) begin
      request(1'b1, 1'b0, '0, 1'b1);
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL ready_drop got %0b want 0", ready_o);
      end
      check_seek("step_up", exp[k], 1'b0);
    end
  endtask
  task automatic test_load();
    logic [AW-1:0] st [4] = '{AW'(90), AW'(1), AW'(500), AW'(89)};
    logic dr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] exp [4] = '{AW'(97), AW'(2), AW'(97), AW'(89)};
    for (int k = 0; k < 4; k++) begin
      request(1'b0, 1'b1, st[k], dr[k]);
      check_seek("load", exp[k], 1'b0);
    end
  endtask
  task automatic test_mid_seek();
    request(1'b0, 1'b1, AW'(90), 1'b1);
    @(negedge clk);
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    check_seek("mid_seek", AW'(97), 1'b0);
    repeat (10) @(negedge clk);
    total++;
    if (prime_o !== AW'(97) || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_seek_dropped got prime=%0d ready=%0b want 97 1", prime_o, ready_o);
    end
    request(1'b1, 1'b1, AW'(50), 1'b1);
    check_seek("load_wins", AW'(53), 1'b0);
  endtask
  task automatic test_wrap();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    dir_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_seek("init_down", AW'(97), 1'b0);
    request(1'b1, 1'b0, '0, 1'b1);
    check_seek("wrap_up", AW'(2), 1'b1);
    request(1'b1, 1'b0, '0, 1'b0);
    check_seek("wrap_down", AW'(97), 1'b1);
  endtask
  task automatic test_reset_mark();
    dir_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    total++;
    if (sieve_done_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_sieve got sieve_done=%0b want 0", sieve_done_o);
    end
    rst = 1'b1;
    #1;
    check_zero("mark_reset");
    @(negedge clk);
    rst = 1'b0;
    check_seek("resieve", AW'(2), 1'b0);
    for (int k = 0; k < 3; k++) begin
      request(1'b1, 1'b0, '0, 1'b1);
      check_seek("resieve_walk", k == 0 ? AW'(3) : k == 1 ? AW'(5) : AW'(7), 1'b0);
    end
    request(1'b1, 1'b0, '0, 1'b1);
    check_seek("resieve_11", AW'(11), 1'b0);
    request(1'b1, 1'b0, '0, 1'b1);
    check_seek("resieve_13", AW'(13), 1'b0);
  endtask
  initial begin
    test_reset();
    test_step_up();
    test_load();
    test_mid_seek();
    test_wrap();
    test_reset_mark();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prime_sieve_stepper.md
Name: prime_sieve_stepper

Overview:
Parametrised successor of the fixed-limit prime stepper. It clears and sieves an internal 1-bit composite bitmap over 0..MAX_N, then steps bidirectionally through primes on request. It supports load-to-value, wrap-around and a ready/done handshake. It sits between the key/tick control logic and the binary-to-BCD and seven-segment display path. It replaces the hard-wired RAM IP with an inferred bitmap, so no external memory IP is needed.

Parameters:
MAX_N, 999999, inclusive upper limit of the sieve; must be >= 3.
AW, 20, width of all value ports; must satisfy 2**AW > MAX_N.

Ports:
clk  in  1  single system clock, all logic on posedge.
rst  in  1  reset, asynchronous assert, active-high; whole block returns to S_CLEAR.
dir_i  in  1  1 = ascending, 0 = descending. Sampled when a step/load is accepted and when the initial seek starts.
step_i  in  1  one-cycle request: advance to the next prime in dir_i. Honoured only while ready_o=1.
load_i  in  1  one-cycle request: seek from start_i. Honoured only while ready_o=1. Wins over step_i when both are high.
start_i  in  AW  load start value.
prime_o  out  AW  current prime.
prime_valid_o  out  1  prime_o holds a valid prime.
ready_o  out  1  block idle in S_READY, requests accepted.
step_done_o  out  1  one-cycle pulse when a seek completes and prime_o updates.
wrap_o  out  1  one-cycle pulse, coincident with step_done_o, when the seek crossed a boundary.
sieve_done_o  out  1  bitmap is valid; stays high until rst.

Behaviour:
- Reset values: prime_o=0, prime_valid_o=0, ready_o=0, step_done_o=0, wrap_o=0, sieve_done_o=0; FSM enters S_CLEAR.
- Bitmap (bit=1 means composite): write 1/cycle; synchronous read with 1-cycle latency; no reset of contents.
- S_CLEAR: write 0 to addresses 0..MAX_N, one per cycle. Takes MAX_N+1 cycles, then go to S_SCAN with i=2.
- S_SCAN: read bit i (2 cycles per candidate).
  - If i*i > MAX_N (compared at 2*AW bits), go to S_INIT.
  - Else if bit=0, set j=i*i and go to S_MARK.
  - Else i=i+1.
- S_MARK: write 1 at j, j=j+i, one write per cycle, while j <= MAX_N (compare without overflow, AW+1 bits). Then i=i+1 and return to S_SCAN.
- S_INIT: set sieve_done_o=1. Perform a seek with cursor=2 if dir_i=1, or cursor=MAX_N if dir_i=0; candidate is included.
- S_READY: ready_o=1.
  - load_i: cursor = clamp(start_i, 2, MAX_N); seek inclusive of cursor.
  - step_i: seek exclusive, first candidate prime_o±1.
  - ready_o drops the cycle after acceptance.
- S_SEEK: 2 cycles per candidate (address issue, data evaluate).
  - Bit=0: prime_o=candidate, prime_valid_o=1, pulse step_done_o, return to S_READY.
  - Bit=1: next candidate in the latched direction.
- Wrap, ascending: a candidate > MAX_N becomes 2.
- Wrap, descending: a candidate < 2 becomes MAX_N.
- Any wrap sets an internal flag that is emitted on wrap_o with step_done_o; at most one wrap per seek.
- step_i/load_i outside S_READY are dropped; there is no queue.
- prime_o holds its old value during a seek. prime_valid_o stays 1 after the first valid prime until rst.
- rst mid-operation: all in-flight state is abandoned and the full clear and sieve are redone.

Optional Feature:
PRIME_COUNT_EN
- Defined: adds output prime_total_o [AW-1:0] and state S_COUNT between S_SCAN completion and S_INIT.
  - S_COUNT reads 2..MAX_N, pipelined at one address per cycle, and counts zero bits.
  - prime_total_o resets to 0 and is valid when sieve_done_o rises; it holds after that.
- Undefined: no port and no state; S_SCAN goes directly to S_INIT.

Decomposition:
- Package prime_sieve_pkg holds:
  - FSM state enum (S_CLEAR, S_SCAN, S_MARK, S_COUNT, S_INIT, S_SEEK, S_READY);
  - localparams DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a clamp function for start values.
- One sub-module, sieve_bitmap: parametrised depth MAX_N+1, 1-bit wide, one write port and one synchronous read port, inferred RAM.

Test Plan:
- MAX_N=100, dir_i=1, release rst → sieve_done_o rises after clear+sieve; prime_o=2, step_done_o pulses once, ready_o=1; prime_total_o=25 when PRIME_COUNT_EN is defined.
- MAX_N=100, dir_i=1, three step_i pulses → prime_o = 3, 5, 7 in turn, one step_done_o each, wrap_o=0.
- MAX_N=100, dir_i=0 at reset release → prime_o=97. Then dir_i=1 and step_i → prime_o=2 with wrap_o=1. Then dir_i=0 and step_i → prime_o=97 with wrap_o=1.
- load_i with start_i=90, dir_i=1 → 97. start_i=1 → 2 (clamped). start_i=500 with dir_i=0 → 97 (clamped to 100). start_i=89 with dir_i=0 → 89 (inclusive).
- step_i pulsed mid-seek, and step_i+load_i together with start_i=50, dir_i=1 → mid-seek request ignored; simultaneous pair gives prime_o=53 with exactly one step_done_o.
- Assert rst during S_MARK → outputs return to reset values immediately; after re-sieve prime_o=2 and the bitmap is correct (spot-check steps to 11, 13).
